uart_rx: RTL and testbench

Serial UART receiver that sits directly upstream of the MMIO bridge's receive path. It samples the asynchronous rx line with 16x oversampling and majority voting, deframes 8N1 characters, and presents each good byte as rx_data with a one-cycle rx_data_valid pulse. Bad stop bits raise framing_error instead. The loopback uart_tx serial output, or the board pin, drives its input.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// clocks-per-sample-tick divisor used by both uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    localparam int DATA_BITS      = 8;
    localparam int DEF_OVERSAMPLE = 16;

    // Clocks per sample tick, rounded to nearest.
    function automatic int tick_div(input int clk_freq, input int baud, input int os);
        return (clk_freq + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick divider: counts 0..DIV-1 and pulses o_tick for one clock at the
// wrap. While i_hold is high the count is pinned at 0 and no tick is issued.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic i_hold,
    output logic o_tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (i_hold || r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tick = !i_hold && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampled 3-sample majority vote
// per bit, registered one-cycle data-valid and framing-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_valid,
    output logic                 framing_error,
    output logic                 rx_busy
);

    localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int M        = OVERSAMPLE / 2;
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS);

    // Compared against the count before the tick advances it, so the samples
    // land on counts M-1, M and M+1 and the vote is made on the last of them.
    localparam logic [SW-1:0] S_LO   = SW'(M - 2);
    localparam logic [SW-1:0] S_MID  = SW'(M - 1);
    localparam logic [SW-1:0] S_HI   = SW'(M);
    localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    uart_state_t          r_state;
    logic                 r_sync1, r_sync2, r_rx_d;
    logic [SW-1:0]        r_scnt;
    logic [BW-1:0]        r_bcnt;
    logic [1:0]           r_smp;
    logic [DATA_BITS-1:0] r_shift;

    logic w_tick, w_fall, w_vote, w_decide, w_bound;

    uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .i_hold (r_state == IDLE),
        .o_tick (w_tick)
    );

    assign w_fall   = r_rx_d & ~r_sync2;
    assign w_vote   = (r_smp[1] & r_smp[0]) | (r_smp[1] & r_sync2) | (r_smp[0] & r_sync2);
    assign w_decide = w_tick && (r_scnt == S_HI);
    assign w_bound  = w_tick && (r_scnt == S_END);
    assign rx_busy  = (r_state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_rx_d        <= 1'b1;
            r_state       <= IDLE;
            r_scnt        <= '0;
            r_bcnt        <= '0;
            r_smp         <= '0;
            r_shift       <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            r_sync1       <= rx;
            r_sync2       <= r_sync1;
            r_rx_d        <= r_sync2;
            rx_data_valid <= 1'b0;
            framing_error <= 1'b0;

            if (r_state != IDLE && w_tick) begin
                r_scnt <= (r_scnt == S_END) ? '0 : r_scnt + 1'b1;
                if (r_scnt == S_LO)  r_smp[0] <= r_sync2;
                if (r_scnt == S_MID) r_smp[1] <= r_sync2;
            end

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_scnt  <= '0;
                        r_bcnt  <= '0;
                    end
                end
                START: begin
                    if (w_decide && w_vote)
                        r_state <= IDLE;
                    else if (w_bound)
                        r_state <= DATA;
                end
                DATA: begin
                    if (w_decide)
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    if (w_bound) begin
                        r_bcnt <= r_bcnt + 1'b1;
                        if (r_bcnt == B_LAST) r_state <= STOP;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop gives half a bit to catch a back-to-back start.
                    if (w_decide) begin
                        if (w_vote) begin
                            rx_data       <= r_shift;
                            rx_data_valid <= 1'b1;
                            r_state       <= IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            r_state       <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (w_tick && r_sync2) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clk/tick, 160 clk/bit.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_valid, framing_error, rx_busy;

    uart_rx #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .framing_error (framing_error),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    int         total = 0, bad = 0;
    int         cyc = 0;
    logic [7:0] vq[$];
    int         vt[$];
    int         fe_cnt = 0, wide_cnt = 0, both_cnt = 0;
    logic       prev_v = 1'b0, prev_f = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_data_valid) begin
            vq.push_back(rx_data);
            vt.push_back(cyc);
        end
        if (framing_error) fe_cnt++;
        if ((rx_data_valid && prev_v) || (framing_error && prev_f)) wide_cnt++;
        if (rx_data_valid && framing_error) both_cnt++;
        prev_v = rx_data_valid;
        prev_f = framing_error;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stp, input int bc, input bit glitch);
        rx = 1'b0;
        wait_clk(bc);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (glitch) begin
                wait_clk(80);
                rx = ~b[i];
                wait_clk(1);
                rx = b[i];
                wait_clk(bc - 81);
            end else begin
                wait_clk(bc);
            end
        end
        rx = stp;
        wait_clk(bc);
    endtask

    function automatic logic [7:0] q_at(input int i);
        return (vq.size() > i) ? vq[i] : 8'hxx;
    endfunction

    initial begin
        int p, n, fe0, lat;

        wait_clk(3);
        chk("rst_data",  {24'h0, rx_data}, 32'h00);
        chk("rst_valid", {31'h0, rx_data_valid}, 32'h0);
        chk("rst_ferr",  {31'h0, framing_error}, 32'h0);
        chk("rst_busy",  {31'h0, rx_busy}, 32'h0);
        reset = 1'b1;
        wait_clk(20);

        // bad stop bit, line held low, then recovery
        send(8'h81, 1'b0, 160, 1'b0);
        wait_clk(500);
        rx = 1'b1;
        wait_clk(200);
        chk("t4_ferr_cnt", fe_cnt, 1);
        chk("t4_no_valid", vq.size(), 0);
        chk("t4_data_hold", {24'h0, rx_data}, 32'h00);
        chk("t4_idle", {31'h0, rx_busy}, 32'h0);
        send(8'h42, 1'b1, 160, 1'b0);
        wait_clk(50);
        chk("t4_cnt2", vq.size(), 1);
        chk("t4_data2", {24'h0, q_at(0)}, 32'h42);

        // single frame and latency
        vq.delete(); vt.delete(); fe0 = fe_cnt;
        p = cyc;
        send(8'h55, 1'b1, 160, 1'b0);
        wait_clk(20);
        chk("t1_cnt", vq.size(), 1);
        chk("t1_data", {24'h0, q_at(0)}, 32'h55);
        lat = (vt.size() > 0) ? vt[0] - p : -1;
        chk("t1_latency_ok", {31'h0, (lat >= 1515 && lat <= 1545)}, 32'h1);
        chk("t1_no_ferr", fe_cnt, fe0);

        // back-to-back frames
        vq.delete(); vt.delete();
        send(8'hA3, 1'b1, 160, 1'b0);
        send(8'h0F, 1'b1, 160, 1'b0);
        wait_clk(20);
        chk("t2_cnt", vq.size(), 2);
        chk("t2_data", {16'h0, q_at(0), q_at(1)}, 32'hA30F);
        n = (vt.size() > 1) ? vt[1] - vt[0] : 0;
        chk("t2_gap_ok", {31'h0, (n >= 1590 && n <= 1610)}, 32'h1);

        // false start
        vq.delete(); vt.delete();
        rx = 1'b0;
        wait_clk(20);
        chk("t3_busy_hi", {31'h0, rx_busy}, 32'h1);
        wait_clk(20);
        rx = 1'b1;
        n = 0;
        while (rx_busy && n < 200) begin
            wait_clk(1);
            n++;
        end
        chk("t3_busy_drop_ok", {31'h0, (n <= 90)}, 32'h1);
        wait_clk(300);
        chk("t3_no_valid", vq.size(), 0);
        chk("t3_no_ferr", fe_cnt, fe0);

        // glitches at mid-bit, then a fast (+3%) frame
        vq.delete(); vt.delete();
        send(8'h3C, 1'b1, 160, 1'b1);
        wait_clk(100);
        send(8'h3C, 1'b1, 155, 1'b0);
        wait_clk(100);
        chk("t5_cnt", vq.size(), 2);
        chk("t5_data", {16'h0, q_at(0), q_at(1)}, 32'h3C3C);

        // reset in the middle of data bit 4
        vq.delete(); vt.delete();
        rx = 1'b0;
        wait_clk(160);
        rx = 1'b1;
        wait_clk(720);
        chk("t6_busy_pre", {31'h0, rx_busy}, 32'h1);
        reset = 1'b0;
        #1;
        chk("t6_rst_data",  {24'h0, rx_data}, 32'h00);
        chk("t6_rst_valid", {31'h0, rx_data_valid}, 32'h0);
        chk("t6_rst_ferr",  {31'h0, framing_error}, 32'h0);
        chk("t6_rst_busy",  {31'h0, rx_busy}, 32'h0);
        wait_clk(3);
        reset = 1'b1;
        wait_clk(1000);
        chk("t6_no_pulse", vq.size(), 0);
        send(8'h5A, 1'b1, 160, 1'b0);
        wait_clk(50);
        chk("t6_cnt", vq.size(), 1);
        chk("t6_data", {24'h0, q_at(0)}, 32'h5A);

        chk("pulse_width", wide_cnt, 0);
        chk("pulse_overlap", both_cnt, 0);
        chk("ferr_total", fe_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
